reg4_bus_ctrl: RTL and testbench
================================

Name: reg4_bus_ctrl

Overview:
- Sequencer at the driving end of the shared 4-bit register bus. It owns the inen/oen strobe pair of every 4-bit register in the datapath.
- Accepts transfer commands over a valid/ready handshake: register-to-register move, immediate load, register read-out.
- Converts each command into a contention-free strobe sequence: drive the bus with oen or the immediate, latch the destination with inen, or capture the bus value for the requester.

Parameters:
- DW, 4, bus and register data width.
- NREG, 4, number of registers on the bus.
- AW, 2, width of register index fields; must satisfy 2^AW >= NREG.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 MOVE, 01 LOADI, 10 READ, 11 reserved.
- cmd_src  in  AW  source register index (MOVE, READ).
- cmd_dst  in  AW  destination register index (MOVE, LOADI).
- cmd_imm  in  DW  immediate value (LOADI).
- oen  out  NREG  one-hot register output enables.
- inen  out  NREG  one-hot register load enables.
- imm_drive  out  1  immediate driver enable onto the bus.
- imm_out  out  DW  immediate value presented to the bus driver.
- bus_in  in  DW  current shared-bus value.
- rd_valid  out  1  read data available.
- rd_ready  in  1  requester accepts read data.
- rd_data  out  DW  captured register value.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  one-cycle pulse for a rejected command.

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE. oen, inen, imm_drive, imm_out, rd_valid, rd_data, err and busy are all 0. cmd_ready=1 after clr deasserts.
- All strobe and data outputs are registered. cmd_ready = (state==IDLE) && !clr-asserted. busy = !IDLE.
- Accept: rising edge with cmd_valid && cmd_ready. The command fields are latched at that edge.
- Command validation, at accept:
  - op=11, or any used index >= NREG: go to ERR.
  - ERR: err=1 for exactly one cycle, no strobes, then IDLE.
- States: IDLE, DRIVE, LATCH, CAPTURE, RESP, ERR.
- MOVE: IDLE -> DRIVE -> LATCH -> IDLE.
  - DRIVE (1 cycle): oen[src]=1.
  - LATCH (1 cycle): oen[src]=1 and inen[dst]=1. The destination loads at the end of LATCH.
  - Next command is accepted in the cycle after LATCH. Accept-to-accept is 3 cycles.
- LOADI: same timing as MOVE, with imm_drive=1 and imm_out=cmd_imm in place of oen.
- READ: IDLE -> DRIVE -> CAPTURE -> RESP -> IDLE.
  - DRIVE: oen[src]=1.
  - CAPTURE: oen[src]=1; rd_data <= bus_in at the end of the cycle.
  - RESP: rd_valid=1 and rd_data stable until the edge with rd_ready=1, then IDLE. No timeout.
  - If rd_ready is already 1 on entering RESP, rd_valid lasts exactly 1 cycle.
- src==dst on MOVE is legal and executes the normal sequence, with oen and inen of the same register both high in LATCH.
- Bus-safety invariants, every cycle:
  - popcount(oen)+imm_drive <= 1.
  - popcount(inen) <= 1.
  - inen is nonzero only in LATCH and only with a driver active.
  - oen/imm_drive never change in the same cycle inen rises.
- rd_data holds its value after RESP until the next CAPTURE.
- Reset mid-operation: all strobes drop immediately (asynchronous). The in-flight command is discarded; no partial inen pulse survives reset.
- cmd_* changes while busy are ignored.

Test Plan:
- Reset: hold clr=0 with cmd_valid=1 -> oen=inen=0, imm_drive=0, rd_valid=0, err=0. After release, cmd_ready=1 and nothing accepted until the first edge.
- LOADI dst=2 imm=4'hA:
  - oen=0 throughout.
  - imm_drive=1 for 2 cycles, imm_out=A.
  - inen=4'b0100 for exactly 1 cycle (second cycle).
  - cmd_ready back 3 cycles after accept.
- MOVE src=2 dst=0 with bench register model (register 2 holds A):
  - oen=4'b0100 for 2 cycles.
  - inen=4'b0001 in the second cycle.
  - Register 0 reads A afterwards.
  - Back-to-back MOVE accepted every 3 cycles.
- READ src=1 (holding 4'h5), rd_ready low for 4 cycles then high -> rd_valid high for 5 cycles, rd_data=5 constant, busy high until the handshake completes.
- Invalid commands:
  - op=11 -> err pulse 1 cycle, no strobes.
  - With NREG=3, MOVE dst=3 -> err pulse, inen stays 0.
- Reset asserted during LATCH of a MOVE -> inen and oen fall without waiting for clk, destination is not loaded (bench model), state returns to IDLE.

Source files
------------

// File: rtl/reg4_bus_ctrl_if.sv
// Command, strobe and read-back signals between the register-bus sequencer
// and its requester/datapath.
interface reg4_bus_ctrl_if #(
    parameter int DW   = 4,
    parameter int NREG = 4,
    parameter int AW   = 2
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [AW-1:0]   cmd_src;
    logic [AW-1:0]   cmd_dst;
    logic [DW-1:0]   cmd_imm;
    logic [NREG-1:0] oen;
    logic [NREG-1:0] inen;
    logic            imm_drive;
    logic [DW-1:0]   imm_out;
    logic [DW-1:0]   bus_in;
    logic            rd_valid;
    logic            rd_ready;
    logic [DW-1:0]   rd_data;
    logic            busy;
    logic            err;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
        output bus_in, rd_ready,
        input  cmd_ready, oen, inen, imm_drive, imm_out,
        input  rd_valid, rd_data, busy, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
        input  bus_in, rd_ready,
        output cmd_ready, oen, inen, imm_drive, imm_out,
        output rd_valid, rd_data, busy, err
    );
endinterface

// File: rtl/reg4_bus_ctrl.sv
// Register-bus sequencer: turns MOVE/LOADI/READ commands into
// contention-free oen/inen strobe sequences on the shared bus.
module reg4_bus_ctrl #(
    parameter int DW   = 4,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input logic           clk,
    input logic           clr,
    reg4_bus_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_LATCH, S_CAPTURE, S_RESP, S_ERR
    } state_t;

    localparam logic [1:0]  OP_MOVE  = 2'd0;
    localparam logic [1:0]  OP_LOADI = 2'd1;
    localparam logic [1:0]  OP_READ  = 2'd2;
    localparam logic [1:0]  OP_RSVD  = 2'd3;
    localparam logic [AW:0] NREG_W   = NREG[AW:0];

    state_t          r_state, w_next;
    logic [1:0]      r_op;
    logic [AW-1:0]   r_src, r_dst;
    logic [DW-1:0]   r_imm;
    logic [NREG-1:0] r_oen, r_inen, w_oen, w_inen;
    logic            r_imm_drive, w_imm_drive;
    logic [DW-1:0]   r_imm_out, w_imm_out;
    logic            r_rd_valid, w_rd_valid;
    logic [DW-1:0]   r_rd_data;
    logic            r_err, w_err;
    logic            w_accept, w_bad_src, w_bad_dst, w_bad;

    assign bus.cmd_ready = (r_state == S_IDLE) && clr;
    assign w_accept  = bus.cmd_valid && bus.cmd_ready;
    assign w_bad_src = (bus.cmd_op != OP_LOADI)
                    && ({1'b0, bus.cmd_src} >= NREG_W);
    assign w_bad_dst = (bus.cmd_op != OP_READ)
                    && ({1'b0, bus.cmd_dst} >= NREG_W);
    assign w_bad     = (bus.cmd_op == OP_RSVD) || w_bad_src || w_bad_dst;

    // Outputs are computed for the next state so every strobe is a flop.
    always_comb begin
        w_next      = r_state;
        w_oen       = '0;
        w_inen      = '0;
        w_imm_drive = 1'b0;
        w_imm_out   = '0;
        w_rd_valid  = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_next = S_ERR;
                        w_err  = 1'b1;
                    end else begin
                        w_next = S_DRIVE;
                        if (bus.cmd_op == OP_LOADI) begin
                            w_imm_drive = 1'b1;
                            w_imm_out   = bus.cmd_imm;
                        end else begin
                            w_oen = NREG'(1) << bus.cmd_src;
                        end
                    end
                end
            end
            S_DRIVE: begin
                if (r_op == OP_LOADI) begin
                    w_imm_drive = 1'b1;
                    w_imm_out   = r_imm;
                end else begin
                    w_oen = NREG'(1) << r_src;
                end
                if (r_op == OP_READ) begin
                    w_next = S_CAPTURE;
                end else begin
                    w_next = S_LATCH;
                    w_inen = NREG'(1) << r_dst;
                end
            end
            S_LATCH: w_next = S_IDLE;
            S_CAPTURE: begin
                w_next     = S_RESP;
                w_rd_valid = 1'b1;
            end
            S_RESP: begin
                w_rd_valid = !bus.rd_ready;
                if (bus.rd_ready) w_next = S_IDLE;
            end
            S_ERR: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= S_IDLE;
            r_op        <= OP_MOVE;
            r_src       <= '0;
            r_dst       <= '0;
            r_imm       <= '0;
            r_oen       <= '0;
            r_inen      <= '0;
            r_imm_drive <= 1'b0;
            r_imm_out   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_oen       <= w_oen;
            r_inen      <= w_inen;
            r_imm_drive <= w_imm_drive;
            r_imm_out   <= w_imm_out;
            r_rd_valid  <= w_rd_valid;
            r_err       <= w_err;
            if (w_accept) begin
                r_op  <= bus.cmd_op;
                r_src <= bus.cmd_src;
                r_dst <= bus.cmd_dst;
                r_imm <= bus.cmd_imm;
            end
            if (r_state == S_CAPTURE) r_rd_data <= bus.bus_in;
        end
    end

    assign bus.oen       = r_oen;
    assign bus.inen      = r_inen;
    assign bus.imm_drive = r_imm_drive;
    assign bus.imm_out   = r_imm_out;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.err       = r_err;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_reg4_bus_ctrl.sv
// Bench for reg4_bus_ctrl: a modelled 4-register datapath on the bus
// plus directed and random command streams against a register-file model.
module tb_reg4_bus_ctrl;
    localparam logic [1:0] OP_MOVE  = 2'd0;
    localparam logic [1:0] OP_LOADI = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_BAD   = 2'd3;

    logic clk = 1'b0;
    logic clr;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   mon_viol = 0;

    logic [3:0] m_reg [4];
    logic [3:0] dp [4];
    logic [3:0] bus_v;
    logic [3:0] p_oen = '0;
    logic [3:0] p_inen = '0;
    logic       p_imm = 1'b0;

    logic [3:0] t_oen [8];
    logic [3:0] t_inen [8];
    logic [3:0] t_immo [8];
    logic       t_imm [8];
    logic       t_rdy [8];
    logic       t_rv [8];
    logic       t_err [8];

    reg4_bus_ctrl_if #(.DW(4), .NREG(4), .AW(2)) b ();
    reg4_bus_ctrl_if #(.DW(4), .NREG(3), .AW(2)) b3 ();

    reg4_bus_ctrl #(.DW(4), .NREG(4), .AW(2)) dut (
        .clk (clk),
        .clr (clr),
        .bus (b)
    );

    reg4_bus_ctrl #(.DW(4), .NREG(3), .AW(2)) dut3 (
        .clk (clk),
        .clr (clr),
        .bus (b3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath: one driver onto the bus, registers load on inen.
    always_comb begin
        bus_v = b.imm_drive ? b.imm_out : 4'h0;
        for (int k = 0; k < 4; k++)
            if (b.oen[k]) bus_v = bus_v | dp[k];
    end
    assign b.bus_in  = bus_v;
    assign b3.bus_in = 4'h0;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (b.inen[k]) dp[k] <= bus_v;
    end

    always @(negedge clk) begin
        if (clr === 1'b1) begin
            if (($countones(b.oen) + int'(b.imm_drive)) > 1
                || $countones(b.inen) > 1
                || (b.inen != 0 && b.oen == 0 && !b.imm_drive)
                || (b.inen != 0 && p_inen == 0
                    && (b.oen != p_oen || b.imm_drive != p_imm)))
                mon_viol <= mon_viol + 1;
        end
        p_oen  <= b.oen;
        p_inen <= b.inen;
        p_imm  <= b.imm_drive;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t required finish earlier", $time);
        $fatal(1);
    end

    task automatic send(input logic [1:0] op, input logic [1:0] s,
                        input logic [1:0] d, input logic [3:0] im);
        int n;
        n = 0;
        while (b.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (b.cmd_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout cmd_ready=%b required 1", b.cmd_ready);
        end
        b.cmd_op    = op;
        b.cmd_src   = s;
        b.cmd_dst   = d;
        b.cmd_imm   = im;
        b.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        b.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (b.busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (b.busy !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout busy=%b required 0", b.busy);
        end
    endtask

    task automatic trace(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            t_oen[i]  = b.oen;
            t_inen[i] = b.inen;
            t_immo[i] = b.imm_out;
            t_imm[i]  = b.imm_drive;
            t_rdy[i]  = b.cmd_ready;
            t_rv[i]   = b.rd_valid;
            t_err[i]  = b.err;
        end
    endtask

    task automatic load_all();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) begin
            v = 4'($urandom_range(0, 15));
            send(OP_LOADI, 2'd0, 2'(k), v);
            wait_idle();
            m_reg[k] = v;
        end
    endtask

    task automatic test_reset();
        clr         = 1'b0;
        b.cmd_valid = 1'b1;
        b.cmd_op    = OP_LOADI;
        b.cmd_src   = 2'd0;
        b.cmd_dst   = 2'd1;
        b.cmd_imm   = 4'h3;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({b.oen, b.inen, b.imm_drive, b.rd_valid, b.err, b.busy} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_outputs oen=%b inen=%b imm=%b rv=%b err=%b busy=%b required all 0",
                     b.oen, b.inen, b.imm_drive, b.rd_valid, b.err, b.busy);
        end
        n_tests++;
        if (b.cmd_ready !== 1'b0 || b.rd_data !== 4'h0 || b.imm_out !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_ready_data ready=%b rd_data=%h imm_out=%h required 0 0 0",
                     b.cmd_ready, b.rd_data, b.imm_out);
        end
        clr = 1'b1;
        #1;
        n_tests++;
        if (b.cmd_ready !== 1'b1 || b.busy !== 1'b0 || b.imm_drive !== 1'b0) begin
            n_fail++;
            $display("FAIL release_idle ready=%b busy=%b imm=%b required 1 0 0",
                     b.cmd_ready, b.busy, b.imm_drive);
        end
        @(posedge clk);
        #1 b.cmd_valid = 1'b0;
        n_tests++;
        if (b.busy !== 1'b1 || b.imm_drive !== 1'b1 || b.imm_out !== 4'h3) begin
            n_fail++;
            $display("FAIL first_accept busy=%b imm=%b imm_out=%h required 1 1 3",
                     b.busy, b.imm_drive, b.imm_out);
        end
        wait_idle();
        n_tests++;
        if (dp[1] !== 4'h3) begin
            n_fail++;
            $display("FAIL first_load reg1=%h required 3", dp[1]);
        end
        load_all();
    endtask

    task automatic test_loadi();
        send(OP_LOADI, 2'd0, 2'd2, 4'hA);
        trace(3);
        m_reg[2] = 4'hA;
        n_tests++;
        if ((t_oen[0] | t_oen[1] | t_oen[2]) !== 4'h0) begin
            n_fail++;
            $display("FAIL loadi_oen oen=%b/%b/%b required 0", t_oen[0], t_oen[1], t_oen[2]);
        end
        n_tests++;
        if ({t_imm[0], t_imm[1], t_imm[2]} !== 3'b110
            || t_immo[0] !== 4'hA || t_immo[1] !== 4'hA) begin
            n_fail++;
            $display("FAIL loadi_imm imm=%b%b%b out=%h/%h required 110 A/A",
                     t_imm[0], t_imm[1], t_imm[2], t_immo[0], t_immo[1]);
        end
        n_tests++;
        if (t_inen[0] !== 4'h0 || t_inen[1] !== 4'b0100 || t_inen[2] !== 4'h0) begin
            n_fail++;
            $display("FAIL loadi_inen inen=%b/%b/%b required 0000/0100/0000",
                     t_inen[0], t_inen[1], t_inen[2]);
        end
        n_tests++;
        if ({t_rdy[0], t_rdy[1], t_rdy[2]} !== 3'b001) begin
            n_fail++;
            $display("FAIL loadi_ready ready=%b%b%b required 001", t_rdy[0], t_rdy[1], t_rdy[2]);
        end
        n_tests++;
        if (dp[2] !== m_reg[2]) begin
            n_fail++;
            $display("FAIL loadi_reg reg2=%h required %h", dp[2], m_reg[2]);
        end
    endtask

    task automatic test_move();
        send(OP_MOVE, 2'd2, 2'd0, 4'h0);
        trace(3);
        m_reg[0] = m_reg[2];
        n_tests++;
        if (t_oen[0] !== 4'b0100 || t_oen[1] !== 4'b0100 || t_oen[2] !== 4'h0
            || (t_imm[0] | t_imm[1]) !== 1'b0) begin
            n_fail++;
            $display("FAIL move_oen oen=%b/%b/%b imm=%b%b required 0100/0100/0000 00",
                     t_oen[0], t_oen[1], t_oen[2], t_imm[0], t_imm[1]);
        end
        n_tests++;
        if (t_inen[0] !== 4'h0 || t_inen[1] !== 4'b0001 || t_inen[2] !== 4'h0) begin
            n_fail++;
            $display("FAIL move_inen inen=%b/%b/%b required 0000/0001/0000",
                     t_inen[0], t_inen[1], t_inen[2]);
        end
        n_tests++;
        if (dp[0] !== m_reg[0]) begin
            n_fail++;
            $display("FAIL move_reg reg0=%h required %h", dp[0], m_reg[0]);
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2;
        send(OP_MOVE, 2'd0, 2'd1, 4'h0);
        a0 = acc_cyc;
        m_reg[1] = m_reg[0];
        send(OP_MOVE, 2'd1, 2'd3, 4'h0);
        a1 = acc_cyc;
        m_reg[3] = m_reg[1];
        send(OP_LOADI, 2'd0, 2'd2, 4'h6);
        a2 = acc_cyc;
        m_reg[2] = 4'h6;
        wait_idle();
        n_tests++;
        if (a1 - a0 != 3 || a2 - a1 != 3) begin
            n_fail++;
            $display("FAIL b2b_spacing gaps=%0d,%0d required 3,3", a1 - a0, a2 - a1);
        end
        n_tests++;
        if (dp[1] !== m_reg[1] || dp[3] !== m_reg[3] || dp[2] !== m_reg[2]) begin
            n_fail++;
            $display("FAIL b2b_regs r1=%h r3=%h r2=%h required %h %h %h",
                     dp[1], dp[3], dp[2], m_reg[1], m_reg[3], m_reg[2]);
        end
        send(OP_MOVE, 2'd1, 2'd1, 4'h0);
        trace(3);
        n_tests++;
        if (t_oen[1] !== 4'b0010 || t_inen[1] !== 4'b0010 || dp[1] !== m_reg[1]) begin
            n_fail++;
            $display("FAIL move_self oen=%b inen=%b reg1=%h required 0010 0010 %h",
                     t_oen[1], t_inen[1], dp[1], m_reg[1]);
        end
    endtask

    task automatic test_read();
        int rv, bad, nb;
        send(OP_LOADI, 2'd0, 2'd1, 4'h5);
        wait_idle();
        m_reg[1] = 4'h5;
        b.rd_ready = 1'b0;
        send(OP_READ, 2'd1, 2'd0, 4'h0);
        trace(2);
        n_tests++;
        if (t_oen[0] !== 4'b0010 || t_oen[1] !== 4'b0010
            || (t_inen[0] | t_inen[1]) !== 4'h0 || (t_rv[0] | t_rv[1]) !== 1'b0) begin
            n_fail++;
            $display("FAIL read_drive oen=%b/%b inen=%b/%b rv=%b%b required 0010/0010 0 00",
                     t_oen[0], t_oen[1], t_inen[0], t_inen[1], t_rv[0], t_rv[1]);
        end
        rv  = 0;
        bad = 0;
        nb  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b.rd_valid === 1'b1) begin
                rv++;
                if (b.rd_data !== m_reg[1]) bad++;
                if (b.busy !== 1'b1) nb++;
                if (rv == 4) begin
                    @(posedge clk);
                    #1 b.rd_ready = 1'b1;
                end
            end else if (rv > 0) begin
                break;
            end
        end
        n_tests++;
        if (rv != 5 || bad != 0 || nb != 0) begin
            n_fail++;
            $display("FAIL read_resp valid_cycles=%0d bad_data=%0d not_busy=%0d required 5 0 0",
                     rv, bad, nb);
        end
        n_tests++;
        if (b.busy !== 1'b0 || b.rd_data !== m_reg[1]) begin
            n_fail++;
            $display("FAIL read_after busy=%b rd_data=%h required 0 %h",
                     b.busy, b.rd_data, m_reg[1]);
        end
        send(OP_READ, 2'd2, 2'd0, 4'h0);
        rv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b.rd_valid === 1'b1) rv++;
        end
        n_tests++;
        if (rv != 1 || b.rd_data !== m_reg[2]) begin
            n_fail++;
            $display("FAIL read_fast valid_cycles=%0d rd_data=%h required 1 %h",
                     rv, b.rd_data, m_reg[2]);
        end
    endtask

    task automatic test_invalid();
        int e;
        logic [2:0] ie, oe;
        send(OP_BAD, 2'd1, 2'd2, 4'h0);
        trace(3);
        n_tests++;
        if ({t_err[0], t_err[1], t_err[2]} !== 3'b100 || t_rdy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_op_err err=%b%b%b ready=%b required 100 1",
                     t_err[0], t_err[1], t_err[2], t_rdy[1]);
        end
        n_tests++;
        if ((t_oen[0] | t_oen[1] | t_inen[0] | t_inen[1]) !== 4'h0
            || (t_imm[0] | t_imm[1]) !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_op_strobes oen=%b/%b inen=%b/%b required 0",
                     t_oen[0], t_oen[1], t_inen[0], t_inen[1]);
        end
        for (int c = 0; c < 3; c++) begin
            b3.cmd_op  = (c == 1) ? OP_READ : OP_MOVE;
            b3.cmd_src = (c == 1) ? 2'd3 : 2'd0;
            b3.cmd_dst = (c == 2) ? 2'd2 : 2'd3;
            b3.cmd_valid = 1'b1;
            @(posedge clk);
            #1 b3.cmd_valid = 1'b0;
            e  = 0;
            ie = '0;
            oe = '0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                e  += int'(b3.err);
                ie |= b3.inen;
                oe |= b3.oen;
            end
            n_tests++;
            if (c < 2 && (e != 1 || ie !== 3'b000 || oe !== 3'b000)) begin
                n_fail++;
                $display("FAIL nreg3_bad case=%0d err_cycles=%0d inen=%b oen=%b required 1 000 000",
                         c, e, ie, oe);
            end else if (c == 2 && (e != 0 || ie !== 3'b100 || oe !== 3'b001)) begin
                n_fail++;
                $display("FAIL nreg3_move err_cycles=%0d inen=%b oen=%b required 0 100 001",
                         e, ie, oe);
            end
        end
    endtask

    task automatic test_reset_latch();
        int c0;
        send(OP_LOADI, 2'd0, 2'd0, 4'h1);
        wait_idle();
        m_reg[0] = 4'h1;
        send(OP_LOADI, 2'd0, 2'd3, 4'h7);
        wait_idle();
        m_reg[3] = 4'h7;
        send(OP_MOVE, 2'd3, 2'd0, 4'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        n_tests++;
        if (b.inen !== 4'b0001 || b.oen !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_latch_pre inen=%b oen=%b required 0001 1000", b.inen, b.oen);
        end
        c0 = cyc;
        #2 clr = 1'b0;
        #1;
        n_tests++;
        if (b.inen !== 4'h0 || b.oen !== 4'h0 || cyc != c0) begin
            n_fail++;
            $display("FAIL rst_latch_async inen=%b oen=%b edges=%0d required 0 0 0",
                     b.inen, b.oen, cyc - c0);
        end
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        #1;
        n_tests++;
        if (b.busy !== 1'b0 || b.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_latch_idle busy=%b ready=%b required 0 1", b.busy, b.cmd_ready);
        end
        n_tests++;
        if (dp[0] !== m_reg[0] || dp[3] !== m_reg[3]) begin
            n_fail++;
            $display("FAIL rst_latch_regs r0=%h r3=%h required %h %h",
                     dp[0], dp[3], m_reg[0], m_reg[3]);
        end
    endtask

    task automatic test_random();
        logic [1:0] op, s, d;
        logic [3:0] im, exp_v, got;
        int dly, seen, want;
        for (int it = 0; it < 60; it++) begin
            op = 2'($urandom_range(0, 2));
            s  = 2'($urandom_range(0, 3));
            d  = 2'($urandom_range(0, 3));
            im = 4'($urandom_range(0, 15));
            if (op == OP_READ) begin
                dly = $urandom_range(0, 3);
                want = (dly == 0) ? 1 : dly;
                b.rd_ready = (dly == 0);
                exp_v = m_reg[s];
                send(op, s, d, im);
                seen = 0;
                got  = 4'h0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (b.rd_valid === 1'b1) begin
                        if (seen == 0) got = b.rd_data;
                        seen++;
                        if (seen >= dly) b.rd_ready = 1'b1;
                    end else if (seen > 0) begin
                        break;
                    end
                end
                n_tests++;
                if (seen != want || got !== exp_v) begin
                    n_fail++;
                    $display("FAIL rand_read it=%0d src=%0d data=%h cycles=%0d required %h %0d",
                             it, s, got, seen, exp_v, want);
                end
            end else begin
                send(op, s, d, im);
                m_reg[d] = (op == OP_LOADI) ? im : m_reg[s];
                wait_idle();
                n_tests++;
                if (dp[d] !== m_reg[d]) begin
                    n_fail++;
                    $display("FAIL rand_write it=%0d op=%0d dst=%0d reg=%h required %h",
                             it, op, d, dp[d], m_reg[d]);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (dp[k] !== m_reg[k]) begin
                n_fail++;
                $display("FAIL rand_final reg%0d=%h required %h", k, dp[k], m_reg[k]);
            end
        end
    endtask

    task automatic test_bus_safety();
        n_tests++;
        if (mon_viol != 0) begin
            n_fail++;
            $display("FAIL bus_safety violations=%0d required 0", mon_viol);
        end
    endtask

    initial begin
        clr          = 1'b0;
        b.cmd_valid  = 1'b0;
        b.cmd_op     = OP_MOVE;
        b.cmd_src    = 2'd0;
        b.cmd_dst    = 2'd0;
        b.cmd_imm    = 4'h0;
        b.rd_ready   = 1'b0;
        b3.cmd_valid = 1'b0;
        b3.cmd_op    = OP_MOVE;
        b3.cmd_src   = 2'd0;
        b3.cmd_dst   = 2'd0;
        b3.cmd_imm   = 4'h0;
        b3.rd_ready  = 1'b1;
        for (int k = 0; k < 4; k++) m_reg[k] = 4'h0;
        test_reset();
        test_loadi();
        test_move();
        test_back_to_back();
        test_read();
        test_invalid();
        test_reset_latch();
        test_random();
        test_bus_safety();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
